// File: rtl/fu_wb_arb_if.sv
// Shared result record and the pipeline-flush interface used by the writeback arbiter.
package fu_wb_arb_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  id;
        logic [5:0]  prd;
        logic [31:0] rdval;
    } fu_output_t;

endpackage

interface squash_if;
    logic valid;

    modport master (output valid);
    modport slave  (input  valid);
endinterface

// File: rtl/fu_wb_arb.sv
// Writeback arbiter: one private FIFO per functional unit, drained round-robin onto a
// single registered writeback port. Units cannot be back-pressured, so issue is warned
// through fu_stall_o once a FIFO has only one free slot left.
module fu_wb_arb
    import fu_wb_arb_pkg::*;
#(
    parameter int NFU   = 3,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  fu_output_t [NFU-1:0] fu_res_i,
    input  logic [NFU-1:0]       fu_res_valid_i,
    output logic [NFU-1:0]       fu_stall_o,
    output fu_output_t           wb_o,
    output logic                 wb_valid_o,
    output logic                 overflow_o,
    squash_if.slave              squash_io
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = $clog2(NFU);
    localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_LVL = CW'(DEPTH - 1);

    fu_output_t     mem     [NFU][DEPTH];
    logic [PW-1:0]  rd_ptr  [NFU];
    logic [PW-1:0]  wr_ptr  [NFU];
    logic [CW-1:0]  count_q [NFU];
    logic [RW-1:0]  rr_q;
    logic           squash;
    logic           grant_any;
    logic [RW-1:0]  winner;
    logic [RW-1:0]  cand;
    logic [NFU-1:0] pop;
    logic [NFU-1:0] push;
    logic [NFU-1:0] drop;

    assign squash = squash_io.valid;

    // Round-robin search from rr_q upward over registered counts; this cycle's pushes are invisible here.
    always_comb begin
        grant_any = 1'b0;
        winner    = '0;
        cand      = '0;
        for (int k = 0; k < NFU; k++) begin
            cand = RW'((int'(rr_q) + k) % NFU);
            if (!grant_any && (count_q[cand] != '0)) begin
                grant_any = 1'b1;
                winner    = cand;
            end
        end
    end

    // Per-FIFO pop/push/drop decisions; squash suppresses both the grant and every push.
    always_comb begin
        pop  = '0;
        push = '0;
        drop = '0;
        for (int i = 0; i < NFU; i++) begin
            pop[i]  = grant_any && !squash && (winner == RW'(i));
            push[i] = fu_res_valid_i[i] && !squash && ((count_q[i] != FULL_LVL) || pop[i]);
            drop[i] = fu_res_valid_i[i] && !squash && (count_q[i] == FULL_LVL) && !pop[i];
        end
    end

    // Stall hint as soon as a FIFO cannot absorb two more results without a pop.
    always_comb begin
        fu_stall_o = '0;
        for (int i = 0; i < NFU; i++) begin
            fu_stall_o[i] = (count_q[i] >= STALL_LVL);
        end
    end

    // FIFO pointers and occupancy; a squash empties every FIFO at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NFU; i++) begin
                rd_ptr[i]  <= '0;
                wr_ptr[i]  <= '0;
                count_q[i] <= '0;
            end
        end else if (squash) begin
            for (int i = 0; i < NFU; i++) begin
                rd_ptr[i]  <= '0;
                wr_ptr[i]  <= '0;
                count_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NFU; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
                if (push[i] && !pop[i]) begin
                    count_q[i] <= count_q[i] + 1'b1;
                end else if (pop[i] && !push[i]) begin
                    count_q[i] <= count_q[i] - 1'b1;
                end
            end
        end
    end

    // FIFO storage needs no reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NFU; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= fu_res_i[i];
            end
        end
    end

    // Registered writeback port and round-robin pointer; wb_o holds its last value when idle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wb_o       <= '0;
            wb_valid_o <= 1'b0;
            rr_q       <= '0;
        end else if (squash) begin
            wb_valid_o <= 1'b0;
        end else if (grant_any) begin
            wb_o       <= mem[winner][rd_ptr[winner]];
            wb_valid_o <= 1'b1;
            rr_q       <= (winner == RW'(NFU - 1)) ? '0 : winner + 1'b1;
        end else begin
            wb_valid_o <= 1'b0;
        end
    end

    // Sticky record that some result was lost; only reset clears it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow_o <= 1'b0;
        end else if (|drop) begin
            overflow_o <= 1'b1;
        end
    end

    // Flag every dropped result in simulation so the offending unit is easy to find.
    always @(posedge clk) begin
        if (rstn) begin
            for (int i = 0; i < NFU; i++) begin
                assert (!drop[i])
                else $warning("fu_wb_arb: result from FU %0d dropped on full FIFO", i);
            end
        end
    end

endmodule

// File: tb/tb_fu_wb_arb.sv
// Directed bench for fu_wb_arb: latency, round-robin order, fill/stall/overflow,
// full push+pop, squash and asynchronous reset, each checked against hand-derived values.
module tb_fu_wb_arb;
    import fu_wb_arb_pkg::*;

    localparam int NFU   = 3;
    localparam int DEPTH = 4;
    localparam fu_output_t NONE = '0;

    logic                 clk;
    logic                 rstn;
    fu_output_t [NFU-1:0] fu_res;
    logic [NFU-1:0]       fu_res_valid;
    logic [NFU-1:0]       fu_stall;
    fu_output_t           wb;
    logic                 wb_valid;
    logic                 overflow;
    int                   checks;
    int                   fails;

    squash_if sq ();

    fu_wb_arb #(.NFU(NFU), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .fu_res_i       (fu_res),
        .fu_res_valid_i (fu_res_valid),
        .fu_stall_o     (fu_stall),
        .wb_o           (wb),
        .wb_valid_o     (wb_valid),
        .overflow_o     (overflow),
        .squash_io      (sq)
    );

    // Free-running 10-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic fu_output_t mk(input logic [5:0] id, input logic [31:0] rdval);
        fu_output_t r;
        r.pc    = 32'h8000_0000 | {26'd0, id};
        r.id    = id;
        r.prd   = id ^ 6'h15;
        r.rdval = rdval;
        return r;
    endfunction

    // Drive one cycle of strobes (and squash), cross the clock edge, then return inputs to idle.
    task automatic applyStimulus(input logic [NFU-1:0] v, input fu_output_t d0,
                                 input fu_output_t d1, input fu_output_t d2, input logic sqv);
        fu_res_valid = v;
        fu_res[0]    = d0;
        fu_res[1]    = d1;
        fu_res[2]    = d2;
        sq.valid     = sqv;
        @(posedge clk);
        #1;
        fu_res_valid = '0;
        fu_res       = '0;
        sq.valid     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic exp_valid, input fu_output_t exp_res);
        checks++;
        assert (wb_valid === exp_valid)
        else begin
            fails++;
            $error("[TB] FAIL %s valid: observed %b expected %b", tag, wb_valid, exp_valid);
        end
        if (exp_valid) begin
            checks++;
            assert (wb === exp_res)
            else begin
                fails++;
                $error("[TB] FAIL %s data: observed %h expected %h", tag, wb, exp_res);
            end
        end
    endtask

    task automatic checkData(input string tag, input fu_output_t exp_res);
        checks++;
        assert (wb === exp_res)
        else begin
            fails++;
            $error("[TB] FAIL %s data: observed %h expected %h", tag, wb, exp_res);
        end
    endtask

    task automatic checkFlags(input string tag, input logic [NFU-1:0] exp_stall, input logic exp_ovf);
        checks++;
        assert (fu_stall === exp_stall)
        else begin
            fails++;
            $error("[TB] FAIL %s stall: observed %b expected %b", tag, fu_stall, exp_stall);
        end
        checks++;
        assert (overflow === exp_ovf)
        else begin
            fails++;
            $error("[TB] FAIL %s overflow: observed %b expected %b", tag, overflow, exp_ovf);
        end
    endtask

    // Linear directed sequence; every sample point sits 1 unit after a rising edge.
    initial begin
        checks       = 0;
        fails        = 0;
        rstn         = 1'b0;
        fu_res_valid = '0;
        fu_res       = '0;
        sq.valid     = 1'b0;

        #12;
        $display("[TB] reset state");
        checkOutput("reset", 1'b0, NONE);
        checkData("reset_wb", NONE);
        checkFlags("reset", 3'b000, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        idle(1);

        $display("[TB] single result from FU1");
        applyStimulus(3'b010, NONE, mk(6'd5, 32'h2A), NONE, 1'b0);
        checkOutput("t1_n1", 1'b0, NONE);
        idle(1);
        checkOutput("t1_n2", 1'b1, mk(6'd5, 32'h2A));
        idle(1);
        checkOutput("t1_n3", 1'b0, NONE);

        $display("[TB] contention starting at FU2");
        applyStimulus(3'b111, mk(6'd10, 32'hA0), mk(6'd11, 32'hA1), mk(6'd12, 32'hA2), 1'b0);
        idle(1);
        checkOutput("t2a_c2", 1'b1, mk(6'd12, 32'hA2));
        idle(1);
        checkOutput("t2a_c3", 1'b1, mk(6'd10, 32'hA0));
        idle(1);
        checkOutput("t2a_c4", 1'b1, mk(6'd11, 32'hA1));
        idle(1);
        checkOutput("t2a_c5", 1'b0, NONE);

        applyStimulus(3'b100, NONE, NONE, mk(6'd13, 32'hB3), 1'b0);
        idle(1);
        checkOutput("t2_fu2", 1'b1, mk(6'd13, 32'hB3));
        idle(1);

        $display("[TB] contention starting at FU0");
        applyStimulus(3'b111, mk(6'd20, 32'hC0), mk(6'd21, 32'hC1), mk(6'd22, 32'hC2), 1'b0);
        idle(1);
        checkOutput("t2b_c2", 1'b1, mk(6'd20, 32'hC0));
        idle(1);
        checkOutput("t2b_c3", 1'b1, mk(6'd21, 32'hC1));
        idle(1);
        checkOutput("t2b_c4", 1'b1, mk(6'd22, 32'hC2));
        idle(1);
        checkOutput("t2b_c5", 1'b0, NONE);

        applyStimulus(3'b001, mk(6'd30, 32'hD0), NONE, NONE, 1'b0);
        idle(1);
        checkOutput("t3_warm", 1'b1, mk(6'd30, 32'hD0));
        idle(1);

        $display("[TB] fill, stall, full push+pop and overflow on FU0");
        applyStimulus(3'b111, mk(6'd40, 32'hE0), mk(6'd51, 32'hF1), mk(6'd61, 32'h61), 1'b0);
        checkFlags("t3_t1", 3'b000, 1'b0);
        applyStimulus(3'b011, mk(6'd41, 32'hE1), mk(6'd52, 32'hF2), NONE, 1'b0);
        checkOutput("t3_t2", 1'b1, mk(6'd51, 32'hF1));
        checkFlags("t3_t2", 3'b000, 1'b0);
        applyStimulus(3'b101, mk(6'd42, 32'hE2), NONE, mk(6'd62, 32'h62), 1'b0);
        checkOutput("t3_t3", 1'b1, mk(6'd61, 32'h61));
        checkFlags("t3_t3", 3'b001, 1'b0);
        applyStimulus(3'b000, NONE, NONE, NONE, 1'b0);
        checkOutput("t3_t4", 1'b1, mk(6'd40, 32'hE0));
        checkFlags("t3_t4", 3'b000, 1'b0);
        applyStimulus(3'b001, mk(6'd43, 32'hE3), NONE, NONE, 1'b0);
        checkOutput("t3_t5", 1'b1, mk(6'd52, 32'hF2));
        checkFlags("t3_t5", 3'b001, 1'b0);
        applyStimulus(3'b001, mk(6'd44, 32'hE4), NONE, NONE, 1'b0);
        checkOutput("t3_t6", 1'b1, mk(6'd62, 32'h62));
        checkFlags("t3_t6", 3'b001, 1'b0);
        applyStimulus(3'b011, mk(6'd45, 32'hE5), mk(6'd53, 32'hF3), NONE, 1'b0);
        checkOutput("t4_t7", 1'b1, mk(6'd41, 32'hE1));
        checkFlags("t4_t7", 3'b001, 1'b0);
        applyStimulus(3'b001, mk(6'd46, 32'hE6), NONE, NONE, 1'b0);
        checkOutput("t3_t8", 1'b1, mk(6'd53, 32'hF3));
        checkFlags("t3_t8", 3'b001, 1'b1);
        idle(1);
        checkOutput("t3_t9", 1'b1, mk(6'd42, 32'hE2));
        checkFlags("t3_t9", 3'b001, 1'b1);
        idle(1);
        checkOutput("t3_t10", 1'b1, mk(6'd43, 32'hE3));
        checkFlags("t3_t10", 3'b000, 1'b1);
        idle(1);
        checkOutput("t3_t11", 1'b1, mk(6'd44, 32'hE4));
        idle(1);
        checkOutput("t3_t12", 1'b1, mk(6'd45, 32'hE5));
        idle(1);
        checkOutput("t3_t13", 1'b0, NONE);

        $display("[TB] squash with queued results");
        applyStimulus(3'b111, mk(6'd7, 32'h70), mk(6'd8, 32'h71), mk(6'd9, 32'h72), 1'b0);
        applyStimulus(3'b011, mk(6'd14, 32'h73), mk(6'd15, 32'h74), NONE, 1'b0);
        checkOutput("t5_s2", 1'b1, mk(6'd8, 32'h71));
        applyStimulus(3'b100, NONE, NONE, mk(6'd16, 32'h75), 1'b1);
        checkOutput("t5_s3", 1'b0, NONE);
        checkFlags("t5_s3", 3'b000, 1'b1);
        idle(1);
        checkOutput("t5_s4", 1'b0, NONE);
        idle(1);
        checkOutput("t5_s5", 1'b0, NONE);
        applyStimulus(3'b101, mk(6'd17, 32'h76), NONE, mk(6'd18, 32'h77), 1'b0);
        checkOutput("t5_s6", 1'b0, NONE);
        idle(1);
        checkOutput("t5_s7", 1'b1, mk(6'd18, 32'h77));
        idle(1);
        checkOutput("t5_s8", 1'b1, mk(6'd17, 32'h76));
        idle(1);
        checkOutput("t5_s9", 1'b0, NONE);

        $display("[TB] asynchronous reset mid-stream");
        applyStimulus(3'b111, mk(6'd24, 32'h80), mk(6'd25, 32'h81), mk(6'd26, 32'h82), 1'b0);
        applyStimulus(3'b101, mk(6'd27, 32'h83), NONE, mk(6'd28, 32'h85), 1'b0);
        checkOutput("t6_r2", 1'b1, mk(6'd25, 32'h81));
        applyStimulus(3'b001, mk(6'd29, 32'h86), NONE, NONE, 1'b0);
        checkOutput("t6_r3", 1'b1, mk(6'd26, 32'h82));
        checkFlags("t6_r3", 3'b001, 1'b1);
        applyStimulus(3'b001, mk(6'd31, 32'h87), NONE, NONE, 1'b0);
        checkOutput("t6_r4", 1'b1, mk(6'd24, 32'h80));
        checkFlags("t6_r4", 3'b001, 1'b1);
        #3;
        rstn = 1'b0;
        #1;
        checkOutput("t6_rst", 1'b0, NONE);
        checkData("t6_rst_wb", NONE);
        checkFlags("t6_rst", 3'b000, 1'b0);
        idle(2);
        @(negedge clk);
        rstn = 1'b1;
        idle(1);
        applyStimulus(3'b011, mk(6'd32, 32'h90), mk(6'd33, 32'h91), NONE, 1'b0);
        checkOutput("t6_q1", 1'b0, NONE);
        idle(1);
        checkOutput("t6_q2", 1'b1, mk(6'd32, 32'h90));
        idle(1);
        checkOutput("t6_q3", 1'b1, mk(6'd33, 32'h91));
        idle(1);
        checkOutput("t6_q4", 1'b0, NONE);
        checkFlags("t6_q4", 3'b000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
